// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and FSM state types for the slave RAM.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] SIZE_4B = 3'b010;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   // WRAP and the reserved encoding are not supported; only 4-byte beats are.
   function automatic logic req_err(input logic [1:0] burst, input logic [2:0] size);
      return (burst == BURST_WRAP) || (burst == 2'b11) || (size != SIZE_4B);
   endfunction

endpackage

// File: rtl/axi3_slave_ram_mem.sv
// Word storage: byte-strobed write port and a registered read port.
// The array itself is never reset; only the read register is.
module axi3_slave_ram_mem #(
   parameter int DEPTH = 256,
   parameter int DW    = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [DW-1:0]   wdata_i,
   input  logic [DW/8-1:0] wstrb_i,
   input  logic            re_i,
   input  logic [AW-1:0]   raddr_i,
   output logic [DW-1:0]   rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < DW/8; i++) begin
            if (wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   // A read in the same cycle as a write to that word sees the old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axi3_slave_ram.sv
// AXI3 slave RAM with independent single-outstanding write and read engines.
// Responses carry the widened interconnect ID back unchanged.
module axi3_slave_ram
   import axi_pkg::*;
#(
   parameter int ID_WIDTH   = 5,
   parameter int ADDR_WIDTH = 32,
   parameter int BUS_WIDTH  = 32,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic [ID_WIDTH-1:0]    AWID,
   input  logic [ADDR_WIDTH-1:0]  AWADDR,
   input  logic [3:0]             AWLEN,
   input  logic [2:0]             AWSIZE,
   input  logic [1:0]             AWBURST,
   input  logic [1:0]             AWLOCK,
   input  logic [3:0]             AWCACHE,
   input  logic [2:0]             AWPROT,
   input  logic                   AWVALID,
   output logic                   AWREADY,
   input  logic [ID_WIDTH-1:0]    WID,
   input  logic [BUS_WIDTH-1:0]   WDATA,
   input  logic [BUS_WIDTH/8-1:0] WSTRB,
   input  logic                   WLAST,
   input  logic                   WVALID,
   output logic                   WREADY,
   output logic [ID_WIDTH-1:0]    BID,
   output logic [1:0]             BRESP,
   output logic                   BVALID,
   input  logic                   BREADY,
   input  logic [ID_WIDTH-1:0]    ARID,
   input  logic [ADDR_WIDTH-1:0]  ARADDR,
   input  logic [3:0]             ARLEN,
   input  logic [2:0]             ARSIZE,
   input  logic [1:0]             ARBURST,
   input  logic [1:0]             ARLOCK,
   input  logic [3:0]             ARCACHE,
   input  logic [2:0]             ARPROT,
   input  logic                   ARVALID,
   output logic                   ARREADY,
   output logic [ID_WIDTH-1:0]    RID,
   output logic [BUS_WIDTH-1:0]   RDATA,
   output logic [3:0]             RRESP,
   output logic                   RLAST,
   output logic                   RVALID,
   input  logic                   RREADY
);

   localparam int IW = $clog2(MEM_DEPTH);

   wr_state_e             wstate_q;
   logic                  awready_q, wready_q, bvalid_q, werr_q;
   logic [1:0]            bresp_q, wburst_q;
   logic [ID_WIDTH-1:0]   wid_q;
   logic [IW-1:0]         widx_q, widx_d;
   logic [3:0]            wlen_q, wcnt_q;
   logic                  w_hs, w_last_beat, w_beat_err, mem_we;

   rd_state_e             rstate_q;
   logic                  arready_q, rvalid_q, rlast_q, rerr_q;
   logic [ID_WIDTH-1:0]   rid_q;
   logic [IW-1:0]         ridx_q, ridx_d, mem_raddr;
   logic [3:0]            rlen_q, rcnt_q;
   logic [1:0]            rburst_q;
   logic                  ar_hs, r_hs, mem_re;
   logic [BUS_WIDTH-1:0]  mem_rdata;

   logic                  unused_ok;

   // ---------------- write engine ----------------
   assign w_hs        = (wstate_q == W_DATA) && WVALID;
   assign w_last_beat = (wcnt_q == wlen_q);
   // Error is sticky: once a beat is bad, no later beat of the burst writes.
   assign w_beat_err  = werr_q || (WID != wid_q) || (WLAST != w_last_beat);
   assign mem_we      = w_hs && !w_beat_err;
   assign widx_d      = (wburst_q == BURST_INCR) ? widx_q + IW'(1) : widx_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         werr_q    <= 1'b0;
         wid_q     <= '0;
         widx_q    <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         wburst_q  <= BURST_FIXED;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (AWVALID) begin
                  wid_q     <= AWID;
                  widx_q    <= AWADDR[2 +: IW];
                  wlen_q    <= AWLEN;
                  wburst_q  <= AWBURST;
                  werr_q    <= req_err(AWBURST, AWSIZE);
                  wcnt_q    <= '0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  wstate_q  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  werr_q <= w_beat_err;
                  if (w_last_beat) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
                     wstate_q <= W_RESP;
                  end else begin
                     wcnt_q <= wcnt_q + 4'd1;
                     widx_q <= widx_d;
                  end
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wstate_q  <= W_IDLE;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   // ---------------- read engine ----------------
   assign ar_hs     = (rstate_q == R_IDLE) && ARVALID;
   assign r_hs      = (rstate_q == R_DATA) && RREADY;
   assign ridx_d    = (rburst_q == BURST_INCR) ? ridx_q + IW'(1) : ridx_q;
   // The RAM read register only moves on a handshake, so a stalled beat holds.
   assign mem_re    = ar_hs || (r_hs && !rlast_q);
   assign mem_raddr = (rstate_q == R_IDLE) ? ARADDR[2 +: IW] : ridx_d;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rerr_q    <= 1'b0;
         rid_q     <= '0;
         ridx_q    <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
         rburst_q  <= BURST_FIXED;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (ARVALID) begin
                  rid_q     <= ARID;
                  ridx_q    <= ARADDR[2 +: IW];
                  rlen_q    <= ARLEN;
                  rburst_q  <= ARBURST;
                  rerr_q    <= req_err(ARBURST, ARSIZE);
                  rcnt_q    <= '0;
                  rlast_q   <= (ARLEN == 4'd0);
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  rstate_q  <= R_DATA;
               end
            end
            R_DATA: begin
               if (r_hs) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     rstate_q  <= R_IDLE;
                  end else begin
                     rcnt_q  <= rcnt_q + 4'd1;
                     ridx_q  <= ridx_d;
                     rlast_q <= ((rcnt_q + 4'd1) == rlen_q);
                  end
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

   axi3_slave_ram_mem #(
      .DEPTH (MEM_DEPTH),
      .DW    (BUS_WIDTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (clr),
      .we_i    (mem_we),
      .waddr_i (widx_q),
      .wdata_i (WDATA),
      .wstrb_i (WSTRB),
      .re_i    (mem_re),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BID     = wid_q;
   assign BRESP   = bresp_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RID     = rid_q;
   assign RLAST   = rlast_q;
   assign RDATA   = rerr_q ? '0 : mem_rdata;
   assign RRESP   = {2'b00, (rerr_q ? RESP_SLVERR : RESP_OKAY)};

   assign unused_ok = ^{AWADDR[1:0], AWADDR[ADDR_WIDTH-1:2+IW], ARADDR[1:0],
                        ARADDR[ADDR_WIDTH-1:2+IW], AWLOCK, AWCACHE, AWPROT,
                        ARLOCK, ARCACHE, ARPROT, RESP_EXOKAY, RESP_DECERR};

endmodule

// File: tb/tb_axi3_slave_ram.sv
// Self-checking bench for axi3_slave_ram against a word-array reference model.
module tb_axi3_slave_ram;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [4:0]  AWID = '0, WID = '0, ARID = '0;
   logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0;
   logic [3:0]  AWLEN = '0, ARLEN = '0, AWCACHE = '0, ARCACHE = '0, WSTRB = '0;
   logic [2:0]  AWSIZE = 3'b010, ARSIZE = 3'b010, AWPROT = '0, ARPROT = '0;
   logic [1:0]  AWBURST = '0, ARBURST = '0, AWLOCK = '0, ARLOCK = '0;
   logic        AWVALID = 0, WLAST = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
   logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
   logic [4:0]  BID, RID;
   logic [1:0]  BRESP;
   logic [31:0] RDATA;
   logic [3:0]  RRESP;

   always #5 clk = ~clk;

   axi3_slave_ram dut (
      .clk(clk), .clr(clr),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [DEPTH];
   logic [31:0] bd [16];
   logic [3:0]  bs [16];
   logic [4:0]  bw [16];
   logic        bl [16];
   logic [31:0] ed [16];
   logic [3:0]  er_resp;
   int          rstall [16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic bad_req(input logic [1:0] burst, input logic [2:0] size);
      return (burst == 2'b10) || (burst == 2'b11) || (size != 3'b010);
   endfunction

   function automatic logic [1:0] model_write(input logic [4:0] id, input logic [31:0] addr,
                                              input int len, input logic [1:0] burst,
                                              input logic [2:0] size);
      logic err = bad_req(burst, size);
      int idx = int'(addr[9:2]);
      for (int b = 0; b <= len; b++) begin
         if (bw[b] !== id || bl[b] !== (b == len)) err = 1'b1;
         if (!err)
            for (int i = 0; i < 4; i++)
               if (bs[b][i]) mem_m[idx][8*i +: 8] = bd[b][8*i +: 8];
         if (burst == 2'b01) idx = (idx + 1) % DEPTH;
      end
      return err ? 2'b10 : 2'b00;
   endfunction

   function automatic void model_read(input logic [31:0] addr, input int len,
                                      input logic [1:0] burst, input logic [2:0] size);
      logic err = bad_req(burst, size);
      int idx = int'(addr[9:2]);
      er_resp = err ? 4'b0010 : 4'b0000;
      for (int b = 0; b <= len; b++) begin
         ed[b] = err ? 32'h0 : mem_m[idx];
         if (burst == 2'b01) idx = (idx + 1) % DEPTH;
      end
   endfunction

   task automatic prep_beats(input logic [4:0] id, input int len);
      for (int b = 0; b < 16; b++) begin
         bd[b] = $urandom;
         bs[b] = 4'hF;
         bw[b] = id;
         bl[b] = (b == len);
      end
   endtask

   task automatic prep_stalls(input int maxst);
      for (int b = 0; b < 16; b++) rstall[b] = $urandom_range(0, maxst);
   endtask

   task automatic aw_send(input logic [4:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size);
      int n = 0;
      AWID = id; AWADDR = addr; AWLEN = 4'(len); AWBURST = burst; AWSIZE = size;
      AWLOCK = 2'($urandom); AWCACHE = 4'($urandom); AWPROT = 3'($urandom);
      AWVALID = 1'b1;
      while (AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("awready", AWREADY, 1'b1);
      @(negedge clk);
      AWVALID = 1'b0;
   endtask

   task automatic w_send(input int len, input int gapmax);
      for (int b = 0; b <= len; b++) begin
         int n = 0;
         WVALID = 1'b0;
         repeat ($urandom_range(0, gapmax)) @(negedge clk);
         WID = bw[b]; WDATA = bd[b]; WSTRB = bs[b]; WLAST = bl[b];
         WVALID = 1'b1;
         while (WREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
         chk("wready", WREADY, 1'b1);
         @(negedge clk);
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
   endtask

   task automatic b_check(input logic [4:0] id, input logic [1:0] resp, input int bdelay);
      chk("bvalid_after_w", BVALID, 1'b1);
      chk("bid", BID, id);
      chk("bresp", BRESP, resp);
      for (int d = 0; d < bdelay; d++) begin
         @(negedge clk);
         chk("bvalid_hold", BVALID, 1'b1);
         chk("bresp_hold", BRESP, resp);
      end
      BREADY = 1'b1;
      @(negedge clk);
      BREADY = 1'b0;
      chk("bvalid_drop", BVALID, 1'b0);
      chk("awready_back", AWREADY, 1'b1);
   endtask

   task automatic ar_send(input logic [4:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size);
      int n = 0;
      ARID = id; ARADDR = addr; ARLEN = 4'(len); ARBURST = burst; ARSIZE = size;
      ARLOCK = 2'($urandom); ARCACHE = 4'($urandom); ARPROT = 3'($urandom);
      ARVALID = 1'b1;
      while (ARREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("arready", ARREADY, 1'b1);
      @(negedge clk);
      ARVALID = 1'b0;
   endtask

   task automatic r_check(input logic [4:0] id, input int len);
      for (int b = 0; b <= len; b++) begin
         chk("rvalid", RVALID, 1'b1);
         chk("rid", RID, id);
         chk("rdata", RDATA, ed[b]);
         chk("rresp", RRESP, er_resp);
         chk("rlast", RLAST, (b == len));
         RREADY = 1'b0;
         for (int s = 0; s < rstall[b]; s++) begin
            @(negedge clk);
            chk("rvalid_stall", RVALID, 1'b1);
            chk("rdata_stall", RDATA, ed[b]);
            chk("rid_stall", RID, id);
            chk("rlast_stall", RLAST, (b == len));
         end
         RREADY = 1'b1;
         @(negedge clk);
      end
      RREADY = 1'b0;
      chk("rvalid_end", RVALID, 1'b0);
      chk("arready_end", ARREADY, 1'b1);
   endtask

   task automatic do_write(input logic [4:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input int gapmax, input int bdelay);
      logic [1:0] resp;
      aw_send(id, addr, len, burst, size);
      w_send(len, gapmax);
      resp = model_write(id, addr, len, burst, size);
      b_check(id, resp, bdelay);
   endtask

   task automatic do_read(input logic [4:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size);
      model_read(addr, len, burst, size);
      ar_send(id, addr, len, burst, size);
      r_check(id, len);
   endtask

   initial begin
      logic [1:0]  resp;
      logic [4:0]  id;
      logic [31:0] addr;
      int          len;
      logic [1:0]  burst;
      logic [2:0]  size;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_awready", AWREADY, 1'b1);
      chk("rst_arready", ARREADY, 1'b1);
      chk("rst_wready", WREADY, 1'b0);
      chk("rst_bvalid", BVALID, 1'b0);
      chk("rst_rvalid", RVALID, 1'b0);
      chk("rst_bid_rid", {BID, RID}, 10'h0);
      chk("rst_rdata", RDATA, 32'h0);
      chk("rst_resp_last", {BRESP, RRESP, RLAST}, 7'h0);
      clr = 1'b1;
      @(negedge clk);

      // fill all of storage with known random data
      for (int k = 0; k < 16; k++) begin
         prep_beats(5'h1F, 15);
         do_write(5'h1F, 32'(k * 64), 15, 2'b01, 3'b010, 0, 0);
      end

      // single write and read back
      prep_beats(5'h11, 0);
      bd[0] = 32'hDEADBEEF;
      do_write(5'h11, 32'h10, 0, 2'b01, 3'b010, 0, 0);
      prep_stalls(0);
      do_read(5'h11, 32'h10, 0, 2'b01, 3'b010);

      // INCR burst wrapping the top of storage, partial strobe on beat 2
      prep_beats(5'h02, 3);
      bs[2] = 4'b0101;
      do_write(5'h02, 32'h3F8, 3, 2'b01, 3'b010, 1, 2);
      prep_stalls(0);
      do_read(5'h03, 32'h3F8, 3, 2'b01, 3'b010);

      // read stalled three cycles on beat 1
      prep_stalls(0);
      rstall[1] = 3;
      do_read(5'h0A, 32'h100, 3, 2'b01, 3'b010);

      // WRAP write is rejected
      prep_beats(5'h06, 1);
      do_write(5'h06, 32'h80, 1, 2'b10, 3'b010, 0, 0);
      prep_stalls(0);
      do_read(5'h06, 32'h80, 1, 2'b01, 3'b010);

      // WID mismatch on beat 0
      prep_beats(5'h07, 0);
      bw[0] = 5'h08;
      do_write(5'h07, 32'h84, 0, 2'b01, 3'b010, 0, 0);
      do_read(5'h07, 32'h84, 0, 2'b01, 3'b010);

      // early WLAST: beat 0 lands, later beats suppressed
      prep_beats(5'h09, 2);
      bl[1] = 1'b1;
      do_write(5'h09, 32'h90, 2, 2'b01, 3'b010, 0, 1);
      do_read(5'h09, 32'h90, 2, 2'b01, 3'b010);

      // missing WLAST on the last beat
      prep_beats(5'h0B, 1);
      bl[1] = 1'b0;
      do_write(5'h0B, 32'hC0, 1, 2'b01, 3'b010, 0, 0);
      do_read(5'h0B, 32'hC0, 1, 2'b01, 3'b010);

      // size error on read and reserved burst on read
      do_read(5'h0C, 32'h90, 1, 2'b01, 3'b001);
      do_read(5'h0D, 32'h90, 0, 2'b11, 3'b010);

      // FIXED burst write then FIXED read
      prep_beats(5'h0E, 2);
      do_write(5'h0E, 32'hA0, 2, 2'b00, 3'b010, 1, 0);
      do_read(5'h0E, 32'hA0, 1, 2'b00, 3'b010);

      // same-cycle write and read of word 8
      prep_beats(5'h03, 0);
      aw_send(5'h03, 32'h20, 0, 2'b01, 3'b010);
      model_read(32'h20, 0, 2'b01, 3'b010);
      fork
         w_send(0, 0);
         ar_send(5'h04, 32'h20, 0, 2'b01, 3'b010);
      join
      resp = model_write(5'h03, 32'h20, 0, 2'b01, 3'b010);
      b_check(5'h03, resp, 0);
      r_check(5'h04, 0);
      do_read(5'h05, 32'h20, 0, 2'b01, 3'b010);

      // reset in the middle of a 4-beat read
      ar_send(5'h15, 32'h200, 3, 2'b01, 3'b010);
      chk("mid_rvalid", RVALID, 1'b1);
      RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
      #1 clr = 1'b0;
      #1;
      chk("clr_rvalid", RVALID, 1'b0);
      chk("clr_arready", ARREADY, 1'b1);
      chk("clr_rlast_rdata", {RLAST, RDATA}, 33'h0);
      #1 clr = 1'b1;
      @(negedge clk);
      prep_stalls(1);
      do_read(5'h16, 32'h200, 3, 2'b01, 3'b010);

      // randomized traffic
      for (int t = 0; t < 30; t++) begin
         int sel;
         id   = 5'($urandom);
         addr = $urandom;
         len  = $urandom_range(0, 15);
         sel  = $urandom_range(0, 9);
         burst = (sel < 4) ? 2'b00 : (sel < 9) ? 2'b01 : 2'($urandom_range(2, 3));
         size = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
         if ($urandom_range(0, 1) == 0) begin
            prep_beats(id, len);
            for (int b = 0; b <= len; b++) bs[b] = 4'($urandom);
            if ($urandom_range(0, 6) == 0) bw[$urandom_range(0, len)] = id ^ 5'h01;
            if ($urandom_range(0, 6) == 0) begin
               int k = $urandom_range(0, len);
               bl[k] = ~bl[k];
            end
            do_write(id, addr, len, burst, size, 2, $urandom_range(0, 3));
         end else begin
            prep_stalls(2);
            do_read(id, addr, len, burst, size);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
